link_sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for the link datapath, used where producer and consumer already share a clock, e.g. between the encoder and the framing logic. It generalises our dual-clock pointer FIFO to arbitrary width and power-of-two depth. It adds an exact fill level, programmable almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags and a high-watermark statistic. Read data is show-ahead: the head word is always presented on `data_out`.

---
 rtl/link_sync_fifo.sv | 108 ++++++++++
 tb/tb_link_sync_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/link_sync_fifo.sv
// Single-clock show-ahead FIFO with exact fill level, programmable thresholds,
// synchronous flush, sticky overflow/underflow flags and a high-watermark.
module link_sync_fifo #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  stat_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH:0]   level_max,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LVL_AF   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   LVL_AE   = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [ADDR_WIDTH:0]   level_max_q, level_max_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_w, empty_w;
  logic                  wr_acc, rd_acc;

  assign full_w  = (level_q == LVL_FULL);
  assign empty_w = (level_q == '0);

  // Flush masks both accepts so nothing is written and pointers reset cleanly.
  assign wr_acc = wr_en & ~full_w  & ~flush;
  assign rd_acc = rd_en & ~empty_w & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_acc && !rd_acc)      level_d = level_q + LVL_ONE;
      else if (rd_acc && !wr_acc) level_d = level_q - LVL_ONE;
    end
  end

  // A set event in the same cycle as stat_clr wins; the watermark restarts
  // from the post-update level.
  always_comb begin
    overflow_d  = (overflow_q  & ~stat_clr) | (wr_en & full_w  & ~flush);
    underflow_d = (underflow_q & ~stat_clr) | (rd_en & empty_w & ~flush);
    if (stat_clr || (level_d > level_max_q)) level_max_d = level_d;
    else                                     level_max_d = level_max_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      level_max_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      level_max_q <= level_max_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out     = mem_q[rd_ptr_q];
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign level        = level_q;
  assign level_max    = level_max_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_link_sync_fifo.sv
// Directed self-checking bench for link_sync_fifo at default parameters.
module tb_link_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       flush = 1'b0;
  logic       stat_clr = 1'b0;
  logic [9:0] data_in = '0;
  logic [9:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] level, level_max;

  int n_cmp = 0;
  int n_err = 0;

  link_sync_fifo #(.DATA_WIDTH(10), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .flush(flush), .stat_clr(stat_clr), .data_out(data_out), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level), .level_max(level_max), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_cmp++; if (level_max !== 3'd0) begin n_err++; $display("FAIL rst_level_max: got %0d want 0", level_max); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL rst_almost_empty: got %b want 1", almost_empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rst_almost_full: got %b want 0", almost_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow: got %b want 0", underflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; data_in = 10'(i);
      tick();
      n_cmp++; if (level !== 3'(i)) begin n_err++; $display("FAIL fill_level: got %0d want %0d", level, i); end
      n_cmp++; if (almost_full !== (i >= 3)) begin n_err++; $display("FAIL fill_almost_full: got %b want %b at level %0d", almost_full, (i >= 3), i); end
      n_cmp++; if (full !== (i == 4)) begin n_err++; $display("FAIL fill_full: got %b want %b at level %0d", full, (i == 4), i); end
      n_cmp++; if (almost_empty !== (i <= 1)) begin n_err++; $display("FAIL fill_almost_empty: got %b want %b at level %0d", almost_empty, (i <= 1), i); end
      n_cmp++; if (data_out !== 10'h001) begin n_err++; $display("FAIL fill_head: got %h want 001", data_out); end
    end
    wr_en = 1'b0;
    n_cmp++; if (level_max !== 3'd4) begin n_err++; $display("FAIL fill_level_max: got %0d want 4", level_max); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (data_out !== 10'(i)) begin n_err++; $display("FAIL drain_data: got %h want %h", data_out, 10'(i)); end
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL drain_level: got %0d want 0", level); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL drain_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 10'h011 + 10'(i);
      tick();
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", full); end
    data_in = 10'h3FF;
    tick();
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d want 4", level); end
    n_cmp++; if (data_out !== 10'h011) begin n_err++; $display("FAIL ovf_head: got %h want 011", data_out); end
    data_in = 10'h3FE; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL ovf_simul_level: got %0d want 3", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_simul_flag: got %b want 1", overflow); end
    n_cmp++; if (data_out !== 10'h012) begin n_err++; $display("FAIL ovf_simul_head: got %h want 012", data_out); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL ovf_simul_full: got %b want 0", full); end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr_flag: got %b want 0", overflow); end
    n_cmp++; if (level_max !== 3'd3) begin n_err++; $display("FAIL ovf_clr_level_max: got %0d want 3", level_max); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (data_out !== 10'h012 + 10'(i)) begin n_err++; $display("FAIL ovf_drain_data: got %h want %h", data_out, 10'h012 + 10'(i)); end
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_underflow();
    wr_en = 1'b1; rd_en = 1'b1; data_in = 10'h155;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL unf_flag: got %b want 1", underflow); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL unf_level: got %0d want 1", level); end
    n_cmp++; if (data_out !== 10'h155) begin n_err++; $display("FAIL unf_head: got %h want 155", data_out); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL unf_empty: got %b want 0", empty); end
    tick();
    rd_en = 1'b0;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL unf_pop_level: got %0d want 0", level); end
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL unf_sticky: got %b want 1", underflow); end
  endtask

  task automatic test_wrap();
    wr_en = 1'b1;
    data_in = 10'h0A0; tick();
    data_in = 10'h0A1; tick();
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n_cmp++; if (data_out !== 10'h0A0 + 10'(k)) begin n_err++; $display("FAIL wrap_data: got %h want %h at k=%0d", data_out, 10'h0A0 + 10'(k), k); end
      data_in = 10'h0A2 + 10'(k);
      tick();
      n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL wrap_level: got %0d want 2 at k=%0d", level, k); end
    end
    wr_en = 1'b0;
    for (int k = 20; k < 22; k++) begin
      n_cmp++; if (data_out !== 10'h0A0 + 10'(k)) begin n_err++; $display("FAIL wrap_tail: got %h want %h", data_out, 10'h0A0 + 10'(k)); end
      tick();
    end
    rd_en = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", empty); end
  endtask

  task automatic test_flush_stat_clr();
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = 10'h031 + 10'(i);
      tick();
    end
    n_cmp++; if (level_max !== 3'd3) begin n_err++; $display("FAIL flush_pre_level_max: got %0d want 3", level_max); end
    flush = 1'b1; data_in = 10'h3FF;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", level); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", empty); end
    n_cmp++; if (level_max !== 3'd3) begin n_err++; $display("FAIL flush_level_max: got %0d want 3", level_max); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL flush_flags: got ovf=%b unf=%b want 0 0", overflow, underflow); end
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    n_cmp++; if (level_max !== 3'd0) begin n_err++; $display("FAIL clr_level_max: got %0d want 0", level_max); end
    rd_en = 1'b1; tick();
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL clr_unf_set: got %b want 1", underflow); end
    stat_clr = 1'b1; tick();
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL clr_set_wins: got %b want 1", underflow); end
    rd_en = 1'b0; tick(); stat_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL clr_flags: got ovf=%b unf=%b want 0 0", overflow, underflow); end
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1; data_in = 10'h0C1; tick();
    data_in = 10'h0C2; tick();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL arst_level: got %0d want 0", level); end
    n_cmp++; if (level_max !== 3'd0) begin n_err++; $display("FAIL arst_level_max: got %0d want 0", level_max); end
    n_cmp++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin n_err++; $display("FAIL arst_empty: got e=%b ae=%b want 1 1", empty, almost_empty); end
    n_cmp++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_err++; $display("FAIL arst_full: got f=%b af=%b want 0 0", full, almost_full); end
    wr_en = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL arst_idle_level: got %0d want 0", level); end
    wr_en = 1'b1; data_in = 10'h2AA; tick(); wr_en = 1'b0;
    n_cmp++; if (data_out !== 10'h2AA || level !== 3'd1) begin n_err++; $display("FAIL arst_rewrite: got data=%h lvl=%0d want 2aa 1", data_out, level); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_flush_stat_clr();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
